// File: rtl/lock_pkg.sv
// Shared definitions for the lock family: operating modes and edge-event bit positions.
package lock_pkg;
  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_SET    = 2'd1,
    MODE_OPEN   = 2'd2,
    MODE_LOCK   = 2'd3
  } mode_t;

  localparam int EV_ENTER  = 0;
  localparam int EV_UNDO   = 1;
  localparam int EV_CANCEL = 2;
  localparam int EV_W      = 3;
endpackage

// File: rtl/multi_lock_core_if.sv
// Keypad-side bundle of the lock core: level inputs from the panel and status back to it.
interface multi_lock_core_if #(
  parameter int N_KEYS = 9,
  parameter int CW     = 2
);
  logic [N_KEYS-1:0] key;
  logic              enter;
  logic              undo;
  logic              cancel;
  logic              set_req;
  logic [1:0]        mode;
  logic [CW-1:0]     cursor;
  logic [N_KEYS-1:0] cur_entry;
  logic              pwset_available;
  logic [3:0]        fail_cnt;
  logic              err;

  modport master (
    output key, enter, undo, cancel, set_req,
    input  mode, cursor, cur_entry, pwset_available, fail_cnt, err
  );
  modport slave (
    input  key, enter, undo, cancel, set_req,
    output mode, cursor, cur_entry, pwset_available, fail_cnt, err
  );
endinterface

// File: rtl/lock_edge_det.sv
// Rising-edge detector: a held level produces a single one-cycle event.
module lock_edge_det #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);
  logic [W-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= level;
  end

  assign rise = level & ~prev;
endmodule

// File: rtl/multi_lock_core.sv
// Multi-key combination lock: code entry with undo/cancel, code change, open and lockout timers.
module multi_lock_core
  import lock_pkg::*;
#(
  parameter int N_KEYS    = 9,
  parameter int PW_LEN    = 4,
  parameter int MAX_TRIES = 3,
  parameter int OPEN_CYC  = 61425,
  parameter int LOCK_CYC  = 61425,
  parameter int IDLE_CYC  = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_KEYS-1:0]         key,
  input  logic                      enter,
  input  logic                      undo,
  input  logic                      cancel,
  input  logic                      set_req,
  output logic [1:0]                mode,
  output logic [$clog2(PW_LEN)-1:0] cursor,
  output logic [N_KEYS-1:0]         cur_entry,
  output logic                      pwset_available,
  output logic [3:0]                fail_cnt,
  output logic                      err
);
  localparam int CW   = $clog2(PW_LEN);
  localparam int TMAX = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = $clog2(IDLE_CYC + 1);

  mode_t             mode_q, mode_d;
  logic [CW-1:0]     cursor_q, cursor_d;
  logic [N_KEYS-1:0] entry_q [PW_LEN];
  logic [N_KEYS-1:0] entry_d [PW_LEN];
  logic [N_KEYS-1:0] code_q  [PW_LEN];
  logic [N_KEYS-1:0] code_d  [PW_LEN];
  logic              pwset_q, pwset_d;
  logic [3:0]        fail_q, fail_d, fail_inc;
  logic              err_q, err_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic              pend_q, pend_d;
  logic [EV_W-1:0]   rise;
  logic              entry_empty, match;

  lock_edge_det #(.W(EV_W)) u_edge (
    .clk   (clk),
    .rst   (rst),
    .level ({cancel, undo, enter}),
    .rise  (rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_NORMAL;
      cursor_q <= '0;
      pwset_q  <= 1'b0;
      fail_q   <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      idle_q   <= '0;
      pend_q   <= 1'b0;
      for (int i = 0; i < PW_LEN; i++) begin
        entry_q[i] <= '0;
        code_q[i]  <= '0;
      end
    end else begin
      mode_q   <= mode_d;
      cursor_q <= cursor_d;
      pwset_q  <= pwset_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
      idle_q   <= idle_d;
      pend_q   <= pend_d;
      for (int i = 0; i < PW_LEN; i++) begin
        entry_q[i] <= entry_d[i];
        code_q[i]  <= code_d[i];
      end
    end
  end

  always_comb begin
    mode_d      = mode_q;
    cursor_d    = cursor_q;
    pwset_d     = pwset_q;
    fail_d      = fail_q;
    err_d       = 1'b0;
    timer_d     = timer_q;
    idle_d      = '0;
    pend_d      = 1'b0;
    fail_inc    = (fail_q == 4'd15) ? 4'd15 : fail_q + 4'd1;
    entry_empty = 1'b1;
    match       = 1'b1;
    for (int i = 0; i < PW_LEN; i++) begin
      entry_d[i] = entry_q[i];
      code_d[i]  = code_q[i];
      if (entry_q[i] != '0) entry_empty = 1'b0;
      if (entry_q[i] != code_q[i]) match = 1'b0;
    end

    case (mode_q)
      MODE_OPEN, MODE_LOCK: begin
        if (timer_q <= TW'(1)) begin
          mode_d  = MODE_NORMAL;
          timer_d = '0;
          if (mode_q == MODE_LOCK) fail_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        // A completed entry is evaluated one clock after the final enter edge.
        if (pend_q) begin
          cursor_d = '0;
          for (int i = 0; i < PW_LEN; i++) entry_d[i] = '0;
          if (pwset_q) begin
            for (int i = 0; i < PW_LEN; i++) code_d[i] = entry_q[i];
            pwset_d = 1'b0;
            mode_d  = MODE_NORMAL;
          end else if (match) begin
            fail_d = '0;
            if (mode_q == MODE_NORMAL) begin
              mode_d  = MODE_OPEN;
              timer_d = TW'(OPEN_CYC);
            end else begin
              pwset_d = 1'b1;
            end
          end else begin
            err_d  = 1'b1;
            fail_d = fail_inc;
            if (fail_inc == 4'(MAX_TRIES)) begin
              mode_d  = MODE_LOCK;
              timer_d = TW'(LOCK_CYC);
            end
          end
        end else if (rise[EV_CANCEL]) begin
          cursor_d = '0;
          pwset_d  = 1'b0;
          mode_d   = MODE_NORMAL;
          for (int i = 0; i < PW_LEN; i++) entry_d[i] = '0;
        end else if (mode_q == MODE_NORMAL && set_req) begin
          mode_d   = MODE_SET;
          cursor_d = '0;
          for (int i = 0; i < PW_LEN; i++) entry_d[i] = '0;
        end else if (mode_q == MODE_SET && !set_req) begin
          mode_d  = MODE_NORMAL;
          pwset_d = 1'b0;
        end else if (rise[EV_ENTER]) begin
          if (cursor_q == CW'(PW_LEN - 1)) pend_d = 1'b1;
          else cursor_d = cursor_q + CW'(1);
        end else if (rise[EV_UNDO]) begin
          if (entry_q[cursor_q] != '0) begin
            for (int i = 0; i < PW_LEN; i++)
              if (i >= int'(cursor_q)) entry_d[i] = '0;
          end else if (cursor_q != '0) begin
            entry_d[cursor_q - CW'(1)] = '0;
            cursor_d = cursor_q - CW'(1);
          end
        end else begin
          entry_d[cursor_q] = entry_q[cursor_q] | key;
          if (key == '0 && !entry_empty) begin
            if (idle_q == IW'(IDLE_CYC - 1)) begin
              cursor_d = '0;
              for (int i = 0; i < PW_LEN; i++) entry_d[i] = '0;
            end else begin
              idle_d = idle_q + IW'(1);
            end
          end
        end
      end
    endcase
  end

  assign mode            = mode_q;
  assign cursor          = cursor_q;
  assign cur_entry       = entry_q[cursor_q];
  assign pwset_available = pwset_q;
  assign fail_cnt        = fail_q;
  assign err             = err_q;
endmodule

// File: tb/tb_multi_lock_core.sv
// Directed bench for multi_lock_core with shortened timers.
module tb_multi_lock_core;
  localparam int NK   = 9;
  localparam int OPEN = 20;
  localparam int LOCK = 30;
  localparam int IDLE = 50;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] exp_q[$];

  multi_lock_core_if #(.N_KEYS(NK), .CW(2)) bus ();

  multi_lock_core #(
    .N_KEYS(NK), .PW_LEN(4), .MAX_TRIES(3),
    .OPEN_CYC(OPEN), .LOCK_CYC(LOCK), .IDLE_CYC(IDLE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .key             (bus.key),
    .enter           (bus.enter),
    .undo            (bus.undo),
    .cancel          (bus.cancel),
    .set_req         (bus.set_req),
    .mode            (bus.mode),
    .cursor          (bus.cursor),
    .cur_entry       (bus.cur_entry),
    .pwset_available (bus.pwset_available),
    .fail_cnt        (bus.fail_cnt),
    .err             (bus.err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [8:0] key;
    logic       en, un, ca, sr;
    logic [1:0] mode;
    logic [1:0] cur;
    logic [8:0] ce;
    logic       pw;
    logic [3:0] fail;
    logic       err;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every err pulse must match the next expected fail_cnt value.
  always @(negedge clk) begin
    if (!rst && bus.err === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL err_unexpected: got err=1 expected no pulse (fail_cnt %0d)", bus.fail_cnt);
      end else begin
        check("err_fail_cnt", 32'(bus.fail_cnt), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_enter();
    bus.enter = 1'b1; tick();
    bus.enter = 1'b0; tick();
  endtask

  task automatic enter_code(input logic [8:0] k0, k1, k2, k3);
    logic [8:0] k [4];
    k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
    for (int p = 0; p < 4; p++) begin
      bus.key = k[p]; tick();
      bus.key = '0;
      press_enter();
    end
  endtask

  task automatic wait_mode_exit(input logic [1:0] m, input int exp_cyc, input string name);
    int cnt;
    cnt = 0;
    while (bus.mode == m && cnt < 1000) begin
      cnt++;
      tick();
    end
    check(name, cnt, exp_cyc);
    check({name, "_then_mode"}, 32'(bus.mode), 0);
  endtask

  task automatic add(input logic [8:0] k, input logic en, un, ca, sr,
                     input logic [1:0] m, c, input logic [8:0] ce,
                     input logic pw, input logic [3:0] f, input logic e);
    vec_t v;
    v.key = k; v.en = en; v.un = un; v.ca = ca; v.sr = sr;
    v.mode = m; v.cur = c; v.ce = ce; v.pw = pw; v.fail = f; v.err = e;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    bus.key = '0; bus.enter = 0; bus.undo = 0; bus.cancel = 0; bus.set_req = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_mode", 32'(bus.mode), 0);
    check("rst_cursor", 32'(bus.cursor), 0);
    check("rst_cur_entry", 32'(bus.cur_entry), 0);
    check("rst_pwset", 32'(bus.pwset_available), 0);
    check("rst_fail_cnt", 32'(bus.fail_cnt), 0);
    check("rst_err", 32'(bus.err), 0);

    // Wrong code {001,0,0,0}, then undo walk-back, held enter, cancel.
    //   key    en un ca sr mode cur ce     pw fail err
    add(9'h001, 0, 0, 0, 0, 0, 0, 9'h001, 0, 0, 0);
    add(9'h000, 1, 0, 0, 0, 0, 1, 9'h000, 0, 0, 0);
    add(9'h000, 0, 0, 0, 0, 0, 1, 9'h000, 0, 0, 0);
    add(9'h000, 1, 0, 0, 0, 0, 2, 9'h000, 0, 0, 0);
    add(9'h000, 0, 0, 0, 0, 0, 2, 9'h000, 0, 0, 0);
    add(9'h000, 1, 0, 0, 0, 0, 3, 9'h000, 0, 0, 0);
    add(9'h000, 0, 0, 0, 0, 0, 3, 9'h000, 0, 0, 0);
    add(9'h000, 1, 0, 0, 0, 0, 3, 9'h000, 0, 0, 0);
    add(9'h000, 0, 0, 0, 0, 0, 0, 9'h000, 0, 1, 1);
    add(9'h000, 0, 0, 0, 0, 0, 0, 9'h000, 0, 1, 0);
    add(9'h002, 0, 0, 0, 0, 0, 0, 9'h002, 0, 1, 0);
    add(9'h000, 1, 0, 0, 0, 0, 1, 9'h000, 0, 1, 0);
    add(9'h004, 1, 0, 0, 0, 0, 1, 9'h004, 0, 1, 0);
    add(9'h000, 0, 0, 0, 0, 0, 1, 9'h004, 0, 1, 0);
    add(9'h000, 1, 0, 0, 0, 0, 2, 9'h000, 0, 1, 0);
    add(9'h008, 0, 0, 0, 0, 0, 2, 9'h008, 0, 1, 0);
    add(9'h000, 0, 1, 0, 0, 0, 2, 9'h000, 0, 1, 0);
    add(9'h000, 0, 0, 0, 0, 0, 2, 9'h000, 0, 1, 0);
    add(9'h000, 0, 1, 0, 0, 0, 1, 9'h000, 0, 1, 0);
    add(9'h000, 0, 0, 0, 0, 0, 1, 9'h000, 0, 1, 0);
    add(9'h000, 0, 1, 0, 0, 0, 0, 9'h000, 0, 1, 0);
    add(9'h000, 0, 0, 0, 0, 0, 0, 9'h000, 0, 1, 0);
    add(9'h000, 0, 1, 0, 0, 0, 0, 9'h000, 0, 1, 0);
    add(9'h000, 0, 0, 0, 0, 0, 0, 9'h000, 0, 1, 0);
    add(9'h010, 0, 0, 0, 0, 0, 0, 9'h010, 0, 1, 0);
    add(9'h000, 0, 0, 1, 0, 0, 0, 9'h000, 0, 1, 0);
    add(9'h000, 0, 0, 0, 0, 0, 0, 9'h000, 0, 1, 0);

    exp_q.push_back(4'd1);
    for (int i = 0; i < vecs.size(); i++) begin
      bus.key = vecs[i].key; bus.enter = vecs[i].en; bus.undo = vecs[i].un;
      bus.cancel = vecs[i].ca; bus.set_req = vecs[i].sr;
      tick();
      check($sformatf("v%0d_mode", i), 32'(bus.mode), 32'(vecs[i].mode));
      check($sformatf("v%0d_cursor", i), 32'(bus.cursor), 32'(vecs[i].cur));
      check($sformatf("v%0d_cur_entry", i), 32'(bus.cur_entry), 32'(vecs[i].ce));
      check($sformatf("v%0d_pwset", i), 32'(bus.pwset_available), 32'(vecs[i].pw));
      check($sformatf("v%0d_fail_cnt", i), 32'(bus.fail_cnt), 32'(vecs[i].fail));
      check($sformatf("v%0d_err", i), 32'(bus.err), 32'(vecs[i].err));
    end
    bus.key = '0; bus.enter = 0; bus.undo = 0; bus.cancel = 0; bus.set_req = 0;

    // Zero stored code: four empty positions open the lock.
    enter_code(9'h0, 9'h0, 9'h0, 9'h0);
    check("open_mode", 32'(bus.mode), 2);
    check("open_fail_cleared", 32'(bus.fail_cnt), 0);
    wait_mode_exit(2'd2, OPEN, "open_cycles");

    // Three wrong codes lock out.
    for (int t = 1; t <= 3; t++) begin
      exp_q.push_back(4'(t));
      enter_code(9'h001, 9'h0, 9'h0, 9'h0);
      check($sformatf("wrong%0d_err", t), 32'(bus.err), 1);
      check($sformatf("wrong%0d_fail_cnt", t), 32'(bus.fail_cnt), 32'(t));
    end
    check("lock_mode", 32'(bus.mode), 3);
    wait_mode_exit(2'd3, LOCK, "lock_cycles");
    check("lock_exit_fail_cnt", 32'(bus.fail_cnt), 0);

    // Code change.
    bus.set_req = 1'b1; tick();
    check("set_mode", 32'(bus.mode), 1);
    enter_code(9'h0, 9'h0, 9'h0, 9'h0);
    check("set_pwset", 32'(bus.pwset_available), 1);
    check("set_mode_hold", 32'(bus.mode), 1);
    enter_code(9'h003, 9'h004, 9'h010, 9'h100);
    check("store_mode", 32'(bus.mode), 0);
    check("store_pwset", 32'(bus.pwset_available), 0);
    bus.set_req = 1'b0; tick();
    check("set_off_mode", 32'(bus.mode), 0);
    exp_q.push_back(4'd1);
    enter_code(9'h0, 9'h0, 9'h0, 9'h0);
    check("old_code_rejected", 32'(bus.fail_cnt), 1);
    enter_code(9'h003, 9'h004, 9'h010, 9'h100);
    check("new_code_opens", 32'(bus.mode), 2);
    wait_mode_exit(2'd2, OPEN, "open2_cycles");

    // Asynchronous reset in the middle of a lockout.
    for (int t = 1; t <= 3; t++) begin
      exp_q.push_back(4'(t));
      enter_code(9'h0, 9'h0, 9'h0, 9'h0);
    end
    check("lock2_mode", 32'(bus.mode), 3);
    repeat (3) tick();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mode", 32'(bus.mode), 0);
    check("async_rst_fail_cnt", 32'(bus.fail_cnt), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    enter_code(9'h0, 9'h0, 9'h0, 9'h0);
    check("rst_code_zero_opens", 32'(bus.mode), 2);
    wait_mode_exit(2'd2, OPEN, "open3_cycles");

    // Held enter advances once; cancel beats enter on the final position.
    bus.enter = 1'b1;
    repeat (10) tick();
    check("held_enter_cursor", 32'(bus.cursor), 1);
    bus.enter = 1'b0; tick();
    press_enter();
    press_enter();
    check("final_pos_cursor", 32'(bus.cursor), 3);
    bus.enter = 1'b1; bus.cancel = 1'b1; tick();
    check("cancel_enter_mode", 32'(bus.mode), 0);
    check("cancel_enter_cursor", 32'(bus.cursor), 0);
    bus.enter = 1'b0; bus.cancel = 1'b0; tick();
    check("cancel_enter_no_compare", 32'(bus.mode), 0);
    check("cancel_enter_err", 32'(bus.err), 0);

    // Idle timeout clears a partial entry but keeps fail_cnt.
    exp_q.push_back(4'd1);
    enter_code(9'h001, 9'h0, 9'h0, 9'h0);
    bus.key = 9'h005; tick();
    bus.key = '0;
    press_enter();
    check("idle_start_cursor", 32'(bus.cursor), 1);
    repeat (IDLE - 2) tick();
    check("idle_before_cursor", 32'(bus.cursor), 1);
    tick();
    check("idle_cursor", 32'(bus.cursor), 0);
    check("idle_cur_entry", 32'(bus.cur_entry), 0);
    check("idle_fail_kept", 32'(bus.fail_cnt), 1);

    repeat (3) tick();
    check("err_pulses_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
